// File: rtl/stage_mem_if.sv
// ---------------------------------------------------------------------------
// stage_mem_if
//   Data-memory port between the memory-access stage (master) and the data
//   memory (slave). One req/ack transaction per load or store.
//
//   req    master->slave  access request, held until ack or abort
//   we     master->slave  1 = store, 0 = load (0 whenever req = 0)
//   addr   master->slave  byte address, ADDR_W bits
//   wdata  master->slave  store data
//   rdata  slave->master  load data, valid only while ack = 1
//   ack    slave->master  access complete this cycle
// ---------------------------------------------------------------------------
interface stage_mem_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/stage_mem.sv
// ---------------------------------------------------------------------------
// stage_mem
//   Memory-access pipeline stage between execute and write-back.
//   Registers the EX outputs, runs a req/ack access on the data-memory port
//   for loads and stores, selects the write-back data and stalls the front of
//   the pipeline while an access is outstanding. An access that waits
//   ACK_TIMEOUT cycles without ack is aborted with a one-cycle mem_err pulse.
//
//   Optional feature macro: MEM_ALIGN_CHECK_EN
//     defined   : loads/stores with opResult[1:0] != 0 are captured but issue
//                 no request; the cycle they occupy the stage raises mem_err.
//     undefined : no alignment check, low address bits go out unchanged.
//
// Ports
//   clk, rst          clock / synchronous active-high reset
//   i_ex_pc           EX pc (debug)
//   i_ex_opResult     ALU result, also the memory address
//   i_ex_memWE        store
//   i_ex_memData      store data
//   i_ex_rfWE         register-file write enable
//   i_ex_rfDst        destination register
//   i_ex_rfSrc        write-back source, 1 = memory read data, else ALU result
//   dm                data-memory port (stage_mem_if.master)
//   o_mem_pc          registered pc (debug)
//   o_mem_rfWE        write-back enable, gated by stall/err
//   o_mem_rfDst       registered destination
//   o_mem_rfData      write-back data
//   o_mem_stall       freeze IF/ID/EX and this stage's input register
//   o_mem_err         one-cycle pulse, access aborted
// ---------------------------------------------------------------------------
module stage_mem #(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_opResult,
    input  logic        i_ex_memWE,
    input  logic [31:0] i_ex_memData,
    input  logic        i_ex_rfWE,
    input  logic [4:0]  i_ex_rfDst,
    input  logic [1:0]  i_ex_rfSrc,

    stage_mem_if.master dm,

    output logic [31:0] o_mem_pc,
    output logic        o_mem_rfWE,
    output logic [4:0]  o_mem_rfDst,
    output logic [31:0] o_mem_rfData,
    output logic        o_mem_stall,
    output logic        o_mem_err
);

    // Counter only has to reach ACK_TIMEOUT-1.
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    // IDLE: nothing outstanding. ACCESS: request on the bus (pending = 1).
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Stage input register
    logic [31:0]       r_pc;
    logic [31:0]       r_opResult;
    logic              r_memWE;
    logic [31:0]       r_memData;
    logic              r_rfWE;
    logic [4:0]        r_rfDst;
    logic [1:0]        r_rfSrc;

    logic [CNT_W-1:0]  r_cnt;

    logic              w_mem_op;
    logic              w_misalign_in;
    logic              w_misalign_q;
    logic              w_timeout;
    logic              w_stall;
    logic              w_err;

    // Incoming instruction needs the memory port.
    assign w_mem_op = i_ex_memWE | (i_ex_rfSrc == 2'd1);

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_misalign_in = w_mem_op & (i_ex_opResult[1:0] != 2'b00);

    // Remembers that the captured instruction was rejected; it turns into
    // the error pulse during the cycle that instruction sits in the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (!w_stall) begin
            r_misalign <= w_misalign_in;
        end
    end

    assign w_misalign_q = r_misalign;
`else
    assign w_misalign_in = 1'b0;
    assign w_misalign_q  = 1'b0;
`endif

    assign w_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state. The state follows the input register: a new
    // instruction is loaded on every non-stalled edge, and it goes to ACCESS
    // only if it is a memory op that passed the alignment check.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!w_stall) begin
            w_state_nxt = (w_mem_op & ~w_misalign_in) ? S_ACCESS : S_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. The last wait cycle without ack aborts instead of
    // stalling, so the pipeline moves on in the same cycle as the error.
    // -----------------------------------------------------------------------
    always_comb begin
        w_stall = 1'b0;
        w_err   = 1'b0;
        if (r_state == S_ACCESS) begin
            if (!dm.ack) begin
                if (w_timeout) begin
                    w_err = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
        end else begin
            w_err = w_misalign_q;
        end
    end

    // -----------------------------------------------------------------------
    // Input register and wait counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_opResult <= '0;
            r_memWE    <= 1'b0;
            r_memData  <= '0;
            r_rfWE     <= 1'b0;
            r_rfDst    <= '0;
            r_rfSrc    <= '0;
        end else if (!w_stall) begin
            r_pc       <= i_ex_pc;
            r_opResult <= i_ex_opResult;
            r_memWE    <= i_ex_memWE;
            r_memData  <= i_ex_memData;
            r_rfWE     <= i_ex_rfWE;
            r_rfDst    <= i_ex_rfDst;
            r_rfSrc    <= i_ex_rfSrc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !w_stall) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Memory port
    // -----------------------------------------------------------------------
    assign dm.req   = (r_state == S_ACCESS);
    assign dm.we    = (r_state == S_ACCESS) & r_memWE;
    assign dm.addr  = r_opResult[ADDR_W-1:0];
    assign dm.wdata = r_memData;

    // -----------------------------------------------------------------------
    // Write-back. Read data is only meaningful in the ack cycle, which is the
    // only cycle a load can have o_mem_rfWE high, so it is not registered.
    // -----------------------------------------------------------------------
    assign o_mem_pc     = r_pc;
    assign o_mem_rfDst  = r_rfDst;
    assign o_mem_rfData = (r_rfSrc == 2'd1) ? dm.rdata : r_opResult;
    assign o_mem_rfWE   = r_rfWE & ~w_stall & ~w_err;
    assign o_mem_stall  = w_stall;
    assign o_mem_err    = w_err;

endmodule

// File: tb/tb_stage_mem.sv
// ---------------------------------------------------------------------------
// tb_stage_mem
//   Directed stimulus for stage_mem with an instruction-level reference
//   model compared every cycle, plus literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_stage_mem;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_opResult;
    logic        i_ex_memWE;
    logic [31:0] i_ex_memData;
    logic        i_ex_rfWE;
    logic [4:0]  i_ex_rfDst;
    logic [1:0]  i_ex_rfSrc;
    logic [31:0] o_mem_pc;
    logic        o_mem_rfWE;
    logic [4:0]  o_mem_rfDst;
    logic [31:0] o_mem_rfData;
    logic        o_mem_stall;
    logic        o_mem_err;

    stage_mem_if #(.ADDR_W(32)) dm ();

    stage_mem #(.ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ex_pc       (i_ex_pc),
        .i_ex_opResult (i_ex_opResult),
        .i_ex_memWE    (i_ex_memWE),
        .i_ex_memData  (i_ex_memData),
        .i_ex_rfWE     (i_ex_rfWE),
        .i_ex_rfDst    (i_ex_rfDst),
        .i_ex_rfSrc    (i_ex_rfSrc),
        .dm            (dm),
        .o_mem_pc      (o_mem_pc),
        .o_mem_rfWE    (o_mem_rfWE),
        .o_mem_rfDst   (o_mem_rfDst),
        .o_mem_rfData  (o_mem_rfData),
        .o_mem_stall   (o_mem_stall),
        .o_mem_err     (o_mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: which instruction occupies the stage, whether it owns
    // a memory access, and how many cycles it has waited for ack.
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic        we;
        logic [31:0] data;
        logic        rfwe;
        logic [4:0]  dst;
        logic [1:0]  src;
    } ins_t;

    ins_t m_ins;
    bit   m_known = 0;
    bit   m_mem   = 0;
    bit   m_mis   = 0;
    int   m_wait  = 0;

    always @(negedge clk) begin
        bit e_stall, e_err, e_wb, needs_mem, bad_align;
        e_stall = 0;
        e_err   = 0;
        if (m_mis) e_err = 1;
        else if (m_mem && !dm.ack) begin
            if (m_wait >= TO - 1) e_err = 1;
            else e_stall = 1;
        end
        e_wb = m_ins.rfwe && !e_stall && !e_err;
        if (m_known) begin
            chk("m_req",   {31'b0, dm.req},      {31'b0, m_mem});
            chk("m_we",    {31'b0, dm.we},       {31'b0, m_mem & m_ins.we});
            if (m_mem) begin
                chk("m_addr",  dm.addr,  m_ins.res);
                chk("m_wdata", dm.wdata, m_ins.data);
            end
            chk("m_pc",    o_mem_pc,                m_ins.pc);
            chk("m_dst",   {27'b0, o_mem_rfDst},    {27'b0, m_ins.dst});
            chk("m_stall", {31'b0, o_mem_stall},    {31'b0, e_stall});
            chk("m_err",   {31'b0, o_mem_err},      {31'b0, e_err});
            chk("m_rfwe",  {31'b0, o_mem_rfWE},     {31'b0, e_wb});
            if (e_wb)
                chk("m_rfdata", o_mem_rfData, (m_ins.src == 2'd1) ? dm.rdata : m_ins.res);
        end
        // What the coming clock edge does to the stage.
        if (rst) begin
            m_known = 1;
            m_ins   = '0;
            m_mem   = 0;
            m_mis   = 0;
            m_wait  = 0;
        end else if (m_known && !e_stall) begin
            m_ins = '{pc: i_ex_pc, res: i_ex_opResult, we: i_ex_memWE, data: i_ex_memData,
                      rfwe: i_ex_rfWE, dst: i_ex_rfDst, src: i_ex_rfSrc};
            needs_mem = i_ex_memWE || (i_ex_rfSrc == 2'd1);
`ifdef MEM_ALIGN_CHECK_EN
            bad_align = needs_mem && (i_ex_opResult[1:0] != 2'b00);
`else
            bad_align = 0;
`endif
            m_mem  = needs_mem && !bad_align;
            m_mis  = bad_align;
            m_wait = 0;
        end else if (m_known) begin
            m_wait++;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] res, input logic we,
                          input logic [31:0] data, input logic rfwe, input logic [4:0] dst,
                          input logic [1:0] src);
        i_ex_pc       = pc;
        i_ex_opResult = res;
        i_ex_memWE    = we;
        i_ex_memData  = data;
        i_ex_rfWE     = rfwe;
        i_ex_rfDst    = dst;
        i_ex_rfSrc    = src;
    endtask

    task automatic bubble(input logic [31:0] pc);
        set_ex(pc, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_st;
        bit  got_err;
        rst      = 1'b1;
        dm.ack   = 1'b0;
        dm.rdata = 32'h0;
        bubble(32'h0);
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req",   {31'b0, dm.req},      32'd0);
        chk("rst_stall", {31'b0, o_mem_stall}, 32'd0);
        chk("rst_rfwe",  {31'b0, o_mem_rfWE},  32'd0);
        chk("rst_err",   {31'b0, o_mem_err},   32'd0);
        chk("rst_pc",    o_mem_pc,             32'd0);

        // ALU op, no memory access
        tick();
        set_ex(32'h100, 32'h1234, 1'b0, 32'h0, 1'b1, 5'd3, 2'd0);
        tick();
        bubble(32'h104);
        @(negedge clk);
        chk("alu_req",  {31'b0, dm.req},     32'd0);
        chk("alu_rfwe", {31'b0, o_mem_rfWE}, 32'd1);
        chk("alu_dst",  {27'b0, o_mem_rfDst}, 32'd3);
        chk("alu_data", o_mem_rfData,        32'h1234);

        // Load at 0x40, ack in the request cycle
        tick();
        set_ex(32'h108, 32'h40, 1'b0, 32'h0, 1'b1, 5'd5, 2'd1);
        tick();
        bubble(32'h10C);
        dm.ack   = 1'b1;
        dm.rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld0_req",   {31'b0, dm.req},      32'd1);
        chk("ld0_addr",  dm.addr,              32'h40);
        chk("ld0_stall", {31'b0, o_mem_stall}, 32'd0);
        chk("ld0_rfwe",  {31'b0, o_mem_rfWE},  32'd1);
        chk("ld0_data",  o_mem_rfData,         32'hDEADBEEF);
        tick();
        dm.ack = 1'b0;
        @(negedge clk);
        chk("ld0_once",  {31'b0, o_mem_rfWE},  32'd0);

        // Store at 0x80, data 0x55, ack after 3 wait cycles; next ALU held upstream
        tick();
        set_ex(32'h200, 32'h80, 1'b1, 32'h55, 1'b0, 5'd0, 2'd0);
        tick();
        set_ex(32'h204, 32'h777, 1'b0, 32'h0, 1'b1, 5'd7, 2'd0);
        n_st = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_mem_stall) n_st++;
            chk("st_we",    {31'b0, dm.we},      32'd1);
            chk("st_addr",  dm.addr,             32'h80);
            chk("st_wdata", dm.wdata,            32'h55);
            chk("st_rfwe",  {31'b0, o_mem_rfWE}, 32'd0);
            chk("st_pc",    o_mem_pc,            32'h200);
            tick();
        end
        chk("st_stalls", n_st, 32'd3);
        dm.ack = 1'b1;
        @(negedge clk);
        chk("st_ack_stall", {31'b0, o_mem_stall}, 32'd0);
        tick();
        dm.ack = 1'b0;
        bubble(32'h208);
        @(negedge clk);
        chk("st_next_rfwe", {31'b0, o_mem_rfWE}, 32'd1);
        chk("st_next_dst",  {27'b0, o_mem_rfDst}, 32'd7);
        chk("st_next_data", o_mem_rfData,        32'h777);

        // Load with no ack: 15 stall cycles then a single error pulse
        tick();
        set_ex(32'h300, 32'h100, 1'b0, 32'h0, 1'b1, 5'd9, 2'd1);
        tick();
        set_ex(32'h304, 32'hA, 1'b0, 32'h0, 1'b1, 5'd10, 2'd0);
        n_st    = 0;
        got_err = 0;
        for (int i = 0; i < 40 && !got_err; i++) begin
            @(negedge clk);
            if (o_mem_err) begin
                got_err = 1;
                chk("to_err_rfwe",  {31'b0, o_mem_rfWE},  32'd0);
                chk("to_err_stall", {31'b0, o_mem_stall}, 32'd0);
            end else if (o_mem_stall) begin
                n_st++;
            end
            tick();
        end
        bubble(32'h308);
        chk("to_err_seen", {31'b0, got_err}, 32'd1);
        chk("to_stalls",   n_st,             32'd15);
        @(negedge clk);
        chk("to_err_once", {31'b0, o_mem_err},   32'd0);
        chk("to_next_rfwe", {31'b0, o_mem_rfWE}, 32'd1);
        chk("to_next_dst",  {27'b0, o_mem_rfDst}, 32'd10);

        // Reset during the 2nd wait cycle of a load; late ack ignored
        tick();
        set_ex(32'h400, 32'h200, 1'b0, 32'h0, 1'b1, 5'd11, 2'd1);
        tick();
        bubble(32'h404);
        @(negedge clk);
        chk("rm_wait1", {31'b0, o_mem_stall}, 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rm_wait2", {31'b0, o_mem_stall}, 32'd1);
        tick();
        rst      = 1'b0;
        dm.ack   = 1'b1;
        dm.rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("rm_req",   {31'b0, dm.req},      32'd0);
        chk("rm_stall", {31'b0, o_mem_stall}, 32'd0);
        chk("rm_rfwe",  {31'b0, o_mem_rfWE},  32'd0);
        chk("rm_err",   {31'b0, o_mem_err},   32'd0);
        tick();
        dm.ack = 1'b0;
        @(negedge clk);
        chk("rm_after", {31'b0, o_mem_rfWE}, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned load: captured, no request, error in the following cycle
        tick();
        set_ex(32'h500, 32'h42, 1'b0, 32'h0, 1'b1, 5'd12, 2'd1);
        tick();
        bubble(32'h504);
        @(negedge clk);
        chk("al_req",   {31'b0, dm.req},      32'd0);
        chk("al_err",   {31'b0, o_mem_err},   32'd1);
        chk("al_rfwe",  {31'b0, o_mem_rfWE},  32'd0);
        chk("al_stall", {31'b0, o_mem_stall}, 32'd0);
        tick();
        @(negedge clk);
        chk("al_once",  {31'b0, o_mem_err},   32'd0);
`else
        // Unaligned load with no check: address bits pass through unchanged
        tick();
        set_ex(32'h500, 32'h43, 1'b0, 32'h0, 1'b1, 5'd12, 2'd1);
        tick();
        bubble(32'h504);
        dm.ack   = 1'b1;
        dm.rdata = 32'h0BADF00D;
        @(negedge clk);
        chk("ua_addr", dm.addr,             32'h43);
        chk("ua_rfwe", {31'b0, o_mem_rfWE}, 32'd1);
        chk("ua_data", o_mem_rfData,        32'h0BADF00D);
        tick();
        dm.ack = 1'b0;
        @(negedge clk);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
